// File: rtl/tcounter_b_if.sv
// Control/status bundle for the tcounter_b timer: start/stop/config in,
// count and event status out.
interface tcounter_b_if #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8,
  parameter int MCNT_W  = 8
);
  logic               start_i;
  logic               stop_i;
  logic               one_shot_i;
  logic [PRESC_W-1:0] prescale_i;
  logic [WIDTH-1:0]   compare_i;
  logic [WIDTH-1:0]   count_o;
  logic               running_o;
  logic               done_o;
  logic               match_o;
  logic [MCNT_W-1:0]  match_count_o;

  modport master (
    output start_i, stop_i, one_shot_i, prescale_i, compare_i,
    input  count_o, running_o, done_o, match_o, match_count_o
  );

  modport slave (
    input  start_i, stop_i, one_shot_i, prescale_i, compare_i,
    output count_o, running_o, done_o, match_o, match_count_o
  );
endinterface

// File: rtl/tcounter_b_core.sv
// Prescaled up-counting timer with compare match, one-shot/auto-reload modes,
// a single-cycle match pulse and a wrapping match event counter.
module tcounter_b_core #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8,
  parameter int MCNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  tcounter_b_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   count;
  logic [PRESC_W-1:0] presc;
  logic [MCNT_W-1:0]  mcnt;
  logic               running, done, match;
  logic               one_shot_q;
  logic [PRESC_W-1:0] prescale_q;
  logic [WIDTH-1:0]   compare_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      presc      <= '0;
      mcnt       <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      one_shot_q <= 1'b0;
      prescale_q <= '0;
      compare_q  <= '0;
    end else begin
      match <= 1'b0;
      if (bus.stop_i) begin
        // stop beats start; in IDLE it is a no-op and any start is dropped
        if (state != IDLE) begin
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      end else if (bus.start_i) begin
        state      <= RUN;
        count      <= '0;
        presc      <= '0;
        mcnt       <= '0;
        running    <= 1'b1;
        done       <= 1'b0;
        one_shot_q <= bus.one_shot_i;
        prescale_q <= bus.prescale_i;
        compare_q  <= bus.compare_i;
      end else if (state == RUN) begin
        if (presc == prescale_q) begin
          presc <= '0;
          if (count == compare_q) begin
            match <= 1'b1;
            mcnt  <= mcnt + 1'b1;
            if (one_shot_q) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              count <= '0;
            end
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign bus.count_o       = count;
  assign bus.running_o     = running;
  assign bus.done_o        = done;
  assign bus.match_o       = match;
  assign bus.match_count_o = mcnt;
endmodule

// File: doc/tcounter_b_core.md
Name: tcounter_b_core

Overview:
- Prescaled up-counting timer with compare match, one-shot/auto-reload modes and a match event pulse.
- This is the timer block that drives the tcounter_b agent interface. Its outputs (count, running, done, match, match_count) are the signals the agent monitors and the interface checker asserts on.
- Standalone and synchronous; configuration is latched on start.

Parameters:
- WIDTH, 16, counter and compare width in bits (2..32).
- PRESC_W, 8, prescaler width in bits (1..16).
- MCNT_W, 8, match event counter width in bits.

Ports:
- clk  input  1  sole clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  single-cycle pulse: (re)start the timer and latch configuration.
- stop_i  input  1  single-cycle pulse: halt the timer.
- one_shot_i  input  1  1 = stop after first match; 0 = auto-reload.
- prescale_i  input  PRESC_W  tick divider; one tick every prescale_i+1 cycles.
- compare_i  input  WIDTH  terminal count value.
- count_o  output  WIDTH  current counter value.
- running_o  output  1  high in the RUN state.
- done_o  output  1  high in the DONE state (one-shot expired).
- match_o  output  1  one-cycle match event pulse.
- match_count_o  output  MCNT_W  matches since last start; wraps modulo 2^MCNT_W.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset=1 at an edge):
  - state=IDLE.
  - count_o, match_count_o, internal prescaler count: 0.
  - running_o, done_o, match_o: 0.
  - Latched configuration: 0.
  - Reset mid-RUN aborts immediately; no match pulse is produced.
- Priority per edge: reset > stop_i > start_i > tick.
- start_i, from any state (including RUN):
  - Latch one_shot_i, prescale_i, compare_i.
  - count=0, prescaler=0, match_count=0, state=RUN.
  - running_o=1 from the next cycle.
- stop_i:
  - RUN -> IDLE: count_o frozen at its current value, prescaler cleared, running_o=0.
  - DONE -> IDLE: done_o=0, count_o held.
  - IDLE: no effect.
  - stop_i and start_i in the same cycle: stop wins, start is ignored.
- Config inputs are only sampled on start_i; changes during RUN have no effect.
- Prescaler (RUN only):
  - Increments each cycle.
  - When it equals prescale_q it returns to 0 and generates a tick.
  - prescale_q=0 gives a tick every cycle.
- On a tick with count != compare_q: count <= count+1.
- On a tick with count == compare_q (match):
  - Next cycle: match_o=1 for exactly one cycle; match_count increments (wraps at 2^MCNT_W).
  - Auto-reload: count <= 0, stay in RUN.
  - One-shot: count holds compare_q, state=DONE, running_o=0, done_o=1.
- Period: (compare_q+1)*(prescale_q+1) cycles from the start edge to the match edge.
- compare_q=0: a match on every tick.
- count never exceeds compare_q, so there is no WIDTH overflow.
- DONE: holds until start_i (restart) or stop_i (to IDLE).
- match_o is never asserted in IDLE or DONE, except in the single cycle after the transition that caused it.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset dominance: assert reset during RUN with count=5 -> next cycle count_o=0, running_o=0, match_o=0, match_count_o=0.
- Auto-reload, basic period: start with prescale=0, compare=3, one_shot=0 -> count_o sequence 0,1,2,3,0,1...; match_o high 1 cycle every 4 cycles; match_count_o=3 after 12 cycles.
- Prescaler, one-shot: start with prescale=2, compare=2, one_shot=1 -> count advances every 3 cycles; match_o 1 cycle at 9 cycles after start; then done_o=1, running_o=0, count_o=2 held.
- Simultaneous controls: start_i and stop_i together while RUN -> IDLE with count frozen; start_i alone while RUN at count=7 -> count_o=0 next cycle, match_count_o=0, new compare_i used.
- Config isolation and compare=0: change compare_i from 3 to 9 mid-RUN -> period stays 4; restart with compare=0, prescale=0 -> match_o high every cycle, match_count_o wraps 255->0 after 256 matches (MCNT_W=8).
- DONE exits: in DONE, stop_i -> IDLE with done_o=0 and count_o held; start_i from DONE -> RUN, count_o=0, done_o=0.
